// File: rtl/line_mem_responder.sv
// Line-wide main-memory responder: one read or write at a time, completed after a fixed LATENCY.
// Optional LMEM_STATS_EN adds saturating completed-read/write counters (rd_cnt, wr_cnt).
module line_mem_responder #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic              m_re,
    input  logic              m_we,
    input  logic [DATA_W-1:0] m_wr_data,
    output logic [DATA_W-1:0] m_rd_data,
    output logic              m_rdy
`ifdef LMEM_STATS_EN
    ,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    state_t            state_reg;
    logic [3:0]        cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              op_wr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rdy_reg;
    logic              commit;

    // Reset on the commit edge aborts the op, so a pending write never lands.
    assign commit = (state_reg == BUSY) && (cnt_reg == 4'd0) && !rst;

    always_ff @(posedge clk) begin
        if (commit && op_wr_reg) begin
            mem[addr_reg] <= wr_data_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            addr_reg    <= '0;
            op_wr_reg   <= 1'b0;
            wr_data_reg <= '0;
            rd_data_reg <= '0;
            rdy_reg     <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (m_re || m_we) begin
                        addr_reg    <= m_addr;
                        op_wr_reg   <= m_we;
                        wr_data_reg <= m_wr_data;
                        cnt_reg     <= CNT_LOAD;
                        rdy_reg     <= 1'b0;
                        state_reg   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == 4'd0) begin
                        if (!op_wr_reg) begin
                            rd_data_reg <= mem[addr_reg];
                        end
                        rdy_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    rdy_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign m_rd_data = rd_data_reg;
    assign m_rdy     = rdy_reg;

`ifdef LMEM_STATS_EN
    logic [15:0] rd_cnt_reg;
    logic [15:0] wr_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_reg <= 16'd0;
            wr_cnt_reg <= 16'd0;
        end else if (commit) begin
            if (op_wr_reg) begin
                if (wr_cnt_reg != 16'hFFFF) wr_cnt_reg <= wr_cnt_reg + 16'd1;
            end else begin
                if (rd_cnt_reg != 16'hFFFF) rd_cnt_reg <= rd_cnt_reg + 16'd1;
            end
        end
    end

    assign rd_cnt = rd_cnt_reg;
    assign wr_cnt = wr_cnt_reg;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a vector table of single ops plus hand sequences
// for busy-ignore, reset mid-write and back-to-back reads.
module tb_line_mem_responder;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic [13:0] m_addr;
    logic        m_re;
    logic        m_we;
    logic [63:0] m_wr_data;
    logic [63:0] m_rd_data;
    logic        m_rdy;
`ifdef LMEM_STATS_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_rd_cnt = 0;
    int exp_wr_cnt = 0;

    line_mem_responder #(.ADDR_W(14), .DATA_W(64), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_addr    (m_addr),
        .m_re      (m_re),
        .m_we      (m_we),
        .m_wr_data (m_wr_data),
        .m_rd_data (m_rd_data),
        .m_rdy     (m_rdy)
`ifdef LMEM_STATS_EN
        ,
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [13:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk_stats(input string name);
`ifdef LMEM_STATS_EN
        chk({name, "_rd_cnt"}, 64'(rd_cnt), 64'(exp_rd_cnt));
        chk({name, "_wr_cnt"}, 64'(wr_cnt), 64'(exp_wr_cnt));
`endif
    endtask

    // Waits (bounded) for m_rdy after the acceptance edge; lat counts edges past acceptance.
    task automatic wait_rdy(inout int lat);
        while (!m_rdy && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic re, input logic we, input logic [13:0] a,
                          input logic [63:0] d, output int lat);
        @(negedge clk);
        m_re = re; m_we = we; m_addr = a; m_wr_data = d;
        @(posedge clk); #1;
        m_re = 1'b0; m_we = 1'b0;
        lat = 0;
        wait_rdy(lat);
    endtask

    initial begin
        int lat;

        vecs[0] = '{1'b0, 1'b1, 14'h0010, 64'hDEAD_BEEF_CAFE_F00D, 64'h0};
        vecs[1] = '{1'b1, 1'b0, 14'h0010, 64'h0,                   64'hDEAD_BEEF_CAFE_F00D};
        vecs[2] = '{1'b1, 1'b1, 14'h3FFF, 64'h1,                   64'hDEAD_BEEF_CAFE_F00D};
        vecs[3] = '{1'b1, 1'b0, 14'h3FFF, 64'h0,                   64'h1};
        vecs[4] = '{1'b0, 1'b1, 14'h0000, 64'h5555_5555_5555_5555, 64'h1};
        vecs[5] = '{1'b0, 1'b1, 14'h0001, 64'h0123_4567_89AB_CDEF, 64'h1};
        vecs[6] = '{1'b1, 1'b0, 14'h0000, 64'h0,                   64'h5555_5555_5555_5555};
        vecs[7] = '{1'b1, 1'b0, 14'h0001, 64'h0,                   64'h0123_4567_89AB_CDEF};
        vecs[8] = '{1'b0, 1'b1, 14'h0020, 64'h1111_2222_3333_4444, 64'h0123_4567_89AB_CDEF};
        vecs[9] = '{1'b1, 1'b0, 14'h0020, 64'h0,                   64'h1111_2222_3333_4444};

        rst = 1'b1; m_re = 1'b0; m_we = 1'b0; m_addr = '0; m_wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_rdy", 64'(m_rdy), 64'h1);
        chk("reset_rd_data", m_rd_data, 64'h0);
        chk_stats("reset");
        $display("reset done");

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
            if (vecs[i].we) exp_wr_cnt++; else exp_rd_cnt++;
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
            chk($sformatf("vec%0d_rd_data", i), m_rd_data, vecs[i].exp_rd);
            chk_stats($sformatf("vec%0d", i));
            $display("vec %0d re=%0b we=%0b addr=%h rd_data=%h lat=%0d",
                     i, vecs[i].re, vecs[i].we, vecs[i].addr, m_rd_data, lat);
        end

        // Inputs changed while busy must be ignored.
        @(negedge clk);
        m_re = 1'b1; m_addr = 14'h0000;
        @(posedge clk); #1;
        m_re = 1'b0; m_addr = 14'h0001; m_we = 1'b1; m_wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        m_we = 1'b0;
        lat = 1;
        wait_rdy(lat);
        exp_rd_cnt++;
        chk("busy_ignore_latency", 64'(lat), 64'(LAT));
        chk("busy_ignore_rd_data", m_rd_data, 64'h5555_5555_5555_5555);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("busy_ignore_idle%0d", k), 64'(m_rdy), 64'h1);
        end
        run_op(1'b1, 1'b0, 14'h0001, 64'h0, lat);
        exp_rd_cnt++;
        chk("busy_ignore_addr1", m_rd_data, 64'h0123_4567_89AB_CDEF);
        chk_stats("busy_ignore");
        $display("busy-ignore sequence rd_data=%h", m_rd_data);

        // Reset in the second BUSY cycle of a write aborts it.
        @(negedge clk);
        m_we = 1'b1; m_addr = 14'h0020; m_wr_data = 64'hAAAA_AAAA_AAAA_AAAA;
        @(posedge clk); #1;
        m_we = 1'b0;
        chk("rst_mid_busy", 64'(m_rdy), 64'h0);
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        exp_rd_cnt = 0; exp_wr_cnt = 0;
        chk("rst_mid_rdy", 64'(m_rdy), 64'h1);
        chk("rst_mid_rd_data", m_rd_data, 64'h0);
        repeat (5) @(posedge clk);
        #1;
        chk("rst_mid_stays_idle", 64'(m_rdy), 64'h1);
        chk_stats("rst_mid");
        $display("reset-mid-write sequence rdy=%0b", m_rdy);

        // Back-to-back reads with m_re held: 2*LAT+1 edges from first acceptance.
        @(negedge clk);
        m_re = 1'b1; m_addr = 14'h3FFF;
        @(posedge clk); #1;
        lat = 0;
        wait_rdy(lat);
        chk("b2b_first_latency", 64'(lat), 64'(LAT));
        chk("b2b_first_rd_data", m_rd_data, 64'h1);
        m_addr = 14'h0010;
        @(posedge clk); #1;
        lat++;
        chk("b2b_rdy_one_cycle", 64'(m_rdy), 64'h0);
        m_re = 1'b0;
        wait_rdy(lat);
        exp_rd_cnt += 2;
        chk("b2b_total_cycles", 64'(lat), 64'(2 * LAT + 1));
        chk("b2b_second_rd_data", m_rd_data, 64'hDEAD_BEEF_CAFE_F00D);
        chk_stats("b2b");
        $display("back-to-back reads total=%0d rd_data=%h", lat, m_rd_data);

        run_op(1'b1, 1'b0, 14'h0020, 64'h0, lat);
        exp_rd_cnt++;
        chk("rst_mid_prior_contents", m_rd_data, 64'h1111_2222_3333_4444);
        chk_stats("final");
        $display("read after aborted write rd_data=%h", m_rd_data);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
